multicycle_cpu: RTL and testbench
=================================

Name: multicycle_cpu

Overview:
Parametrised multi-cycle successor to the single-cycle core. Fetches instructions and accesses data memory over req/ack handshakes, so wait-states are tolerated. Executes an RV32I integer subset through a five-state FSM, with configurable datapath width, register count and reset PC. Sits between the instruction/data memory interfaces and the system top.

Parameters:
XLEN, 32, datapath/register width; legal values 32 or 64; instructions are always 32 bits.
NREGS, 32, architectural register count; 16 (RV32E-style) or 32.
RESET_PC, 0, PC value loaded at reset (XLEN bits).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
imem_req  output  1  instruction fetch request; held until imem_ack.
imem_addr  output  XLEN  fetch address (equals pc).
imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  input  32  instruction word.
dmem_req  output  1  data access request; held until dmem_ack.
dmem_we  output  1  1 = store, 0 = load; stable while dmem_req is high.
dmem_addr  output  XLEN  data address (rs1 + imm).
dmem_wdata  output  XLEN  store data (rs2).
dmem_ack  input  1  access complete; dmem_rdata valid this cycle for loads.
dmem_rdata  input  XLEN  load data.
pc  output  XLEN  current PC.
retire  output  1  one-cycle pulse in WB when an instruction commits.
trap  output  1  sticky error flag; core halted.

Behaviour:
- Reset is synchronous, active-high.
  - Reset values: pc = RESET_PC; state = FETCH; all registers 0; imem_req = dmem_req = dmem_we = retire = trap = 0.
  - dmem_addr and dmem_wdata reset to 0.
- FETCH:
  - imem_req = 1 with imem_addr = pc.
  - On imem_ack, latch imem_rdata into IR and go to DECODE.
  - imem_req drops in the cycle after the ack.
- DECODE:
  - Read rs1/rs2 and generate the sign-extended immediate (I/S/B/U/J formats to XLEN) into holding registers.
  - Go to EXEC, or to TRAP on an illegal opcode/funct, or when any used register index >= NREGS.
- EXEC:
  - Compute the ALU result and branch target.
  - LOAD/STORE: go to MEM. If the address is misaligned (low log2(XLEN/8) bits != 0), go to TRAP.
  - All other instructions go to WB.
- MEM:
  - dmem_req = 1; addr, we and wdata held constant until dmem_ack.
  - On ack, a load latches dmem_rdata; go to WB.
- WB:
  - Write rd unless rd = 0 (x0 reads 0 always).
  - retire = 1 for one cycle.
  - Update pc: pc+4 normally; target for a taken branch or JAL (JAL writes pc+4 to rd).
  - Go to FETCH.
- TRAP:
  - trap = 1; no further requests issued. Exit only by rst.
- Supported instructions:
  - ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - LW (XLEN=32) / LD (XLEN=64), SW / SD.
  - BEQ, BNE, BLT, BGE.
  - LUI, JAL.
- Arithmetic rules:
  - Wrap modulo 2^XLEN.
  - Shift amount uses the low log2(XLEN) bits.
  - LUI writes the sign-extended imm<<12.
- Latency: ALU/branch/jump = 4 cycles; load/store = 5 cycles (zero wait-state memory). Each wait-state adds 1 cycle.
- Write/read ordering: a write in WB is visible to the next instruction's DECODE; no bypassing is needed.
- Reset during an outstanding request: request drops next cycle; a late ack is ignored (FETCH only samples ack while imem_req = 1).
- An ack arriving when no request is outstanding is ignored.

Optional Feature:
- Macro: MULTICYCLE_CPU_PERF_EN.
- When defined:
  - Adds outputs cycle_count (64 bits) and instret_count (64 bits).
  - cycle_count increments every non-reset cycle while not in TRAP.
  - instret_count increments on every retire.
  - Both reset to 0 and wrap on overflow.
- When undefined: the ports and counters are absent; core behaviour is identical.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2, with imem_ack zero-wait -> x3 = 2; retire pulses every 4 cycles; pc = 12 after third retire.
- SW x3,8(x0) then LW x4,8(x0), with dmem_ack delayed 3 cycles -> dmem_req, dmem_addr = 8 and dmem_wdata = 2 held stable throughout; x4 = 2; each access takes 8 cycles.
- BNE x1,x0,-8 with x1 = 5 -> pc moves back 8. BEQ same operands -> pc+4. JAL x5,16 -> x5 = old pc+4.
- ADDI x0,x0,7 then ADD x6,x0,x0 -> x6 = 0. Illegal opcode 0x7F -> trap = 1, no further imem_req, held until rst.
- Assert rst mid-FETCH while imem_req = 1, then pulse imem_ack -> pc = RESET_PC, imem_req = 0 after the reset cycle, no retire, ack ignored. Repeat with NREGS = 16: ADD x20 -> trap.

Source files
------------

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I-subset core with req/ack instruction and data memory ports.
// Optional MULTICYCLE_CPU_PERF_EN adds 64-bit cycle and retired-instruction counters.
module multicycle_cpu #(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] pc,
   output logic            retire,
`ifdef MULTICYCLE_CPU_PERF_EN
   output logic [63:0]     cycle_count,
   output logic [63:0]     instret_count,
`endif
   output logic            trap
);

   localparam int         SHW  = $clog2(XLEN);
   localparam int         ALW  = $clog2(XLEN / 8);
   localparam int         RIW  = $clog2(NREGS);
   localparam logic [5:0] NR   = 6'(NREGS);
   localparam logic [2:0] LSF3 = (XLEN == 64) ? 3'b011 : 3'b010;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   state_t state, state_nx;

   logic [31:0]     ir;
   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] a, b, imm, res, tgt;
   logic            taken;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rd, rs1, rs2;

   assign opc = ir[6:0];
   assign rd  = ir[11:7];
   assign f3  = ir[14:12];
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign f7  = ir[31:25];

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = XLEN'($signed(ir[31:20]));
   assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
   assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

   // Decode: legality, which register fields are live, and the immediate.
   logic            legal, use1, use2, wr, bad_reg;
   logic [XLEN-1:0] imm_d;
   always_comb begin
      legal = 1'b0;
      use1  = 1'b0;
      use2  = 1'b0;
      wr    = 1'b0;
      imm_d = '0;
      case (opc)
         OP_R: begin
            use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         end
         OP_I: begin
            use1 = 1'b1; wr = 1'b1; imm_d = imm_i;
            case (f3)
               3'd1:    legal = (ir[31:20+SHW] == '0);
               3'd5:    legal = !ir[31] && (ir[29:20+SHW] == '0);
               3'd3:    legal = 1'b0;
               default: legal = 1'b1;
            endcase
         end
         OP_LD:  begin use1 = 1'b1; wr = 1'b1; imm_d = imm_i; legal = (f3 == LSF3); end
         OP_ST:  begin use1 = 1'b1; use2 = 1'b1; imm_d = imm_s; legal = (f3 == LSF3); end
         OP_BR:  begin
            use1 = 1'b1; use2 = 1'b1; imm_d = imm_b;
            legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
         end
         OP_LUI: begin wr = 1'b1; imm_d = imm_u; legal = 1'b1; end
         OP_JAL: begin wr = 1'b1; imm_d = imm_j; legal = 1'b1; end
         default: legal = 1'b0;
      endcase
      bad_reg = (use1 && {1'b0, rs1} >= NR) || (use2 && {1'b0, rs2} >= NR) ||
                (wr && {1'b0, rd} >= NR);
   end

   // Execute: ALU, effective address and branch condition from held operands.
   logic [XLEN-1:0]        opb, alu, ea, res_x;
   logic signed [XLEN-1:0] sra_v;
   logic [SHW-1:0]         sh;
   logic                   br_t, misalign, is_mem;
   always_comb begin
      opb   = (opc == OP_R || opc == OP_BR) ? b : imm;
      sh    = opb[SHW-1:0];
      sra_v = $signed(a) >>> sh;
      ea    = a + imm;
      case (f3)
         3'd0:    alu = (opc == OP_R && ir[30]) ? a - opb : a + opb;
         3'd1:    alu = a << sh;
         3'd2:    alu = XLEN'($signed(a) < $signed(opb));
         3'd3:    alu = XLEN'(a < opb);
         3'd4:    alu = a ^ opb;
         3'd5:    alu = ir[30] ? sra_v : a >> sh;
         3'd6:    alu = a | opb;
         default: alu = a & opb;
      endcase
      case (opc)
         OP_R, OP_I: res_x = alu;
         OP_LUI:     res_x = imm;
         OP_JAL:     res_x = pc + XLEN'(4);
         default:    res_x = ea;
      endcase
      case (f3)
         3'd0:    br_t = (a == b);
         3'd1:    br_t = (a != b);
         3'd4:    br_t = ($signed(a) < $signed(b));
         default: br_t = ($signed(a) >= $signed(b));
      endcase
      misalign = |ea[ALW-1:0];
      is_mem   = (opc == OP_LD) || (opc == OP_ST);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  if (imem_req && imem_ack) state_nx = S_DECODE;
         S_DECODE: state_nx = (!legal || bad_reg) ? S_TRAP : S_EXEC;
         S_EXEC:   state_nx = is_mem ? (misalign ? S_TRAP : S_MEM) : S_WB;
         S_MEM:    if (dmem_req && dmem_ack) state_nx = S_WB;
         S_WB:     state_nx = S_FETCH;
         default:  state_nx = S_TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         ir         <= '0;
         a          <= '0;
         b          <= '0;
         imm        <= '0;
         res        <= '0;
         tgt        <= '0;
         taken      <= 1'b0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         // Request is registered so it rises one cycle after reset and drops after the ack.
         imem_req <= (state_nx == S_FETCH);
         case (state)
            S_FETCH:  if (imem_req && imem_ack) ir <= imem_rdata;
            S_DECODE: begin
               a   <= regs[rs1[RIW-1:0]];
               b   <= regs[rs2[RIW-1:0]];
               imm <= imm_d;
            end
            S_EXEC: begin
               res   <= res_x;
               tgt   <= pc + imm;
               taken <= ((opc == OP_BR) && br_t) || (opc == OP_JAL);
               if (state_nx == S_MEM) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= (opc == OP_ST);
                  dmem_addr  <= ea;
                  dmem_wdata <= b;
               end
            end
            S_MEM: if (dmem_req && dmem_ack) begin
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               if (!dmem_we) res <= dmem_rdata;
            end
            S_WB: begin
               if (wr && rd != 5'd0) regs[rd[RIW-1:0]] <= res;
               pc <= taken ? tgt : pc + XLEN'(4);
            end
            default: ;
         endcase
      end
   end

   assign imem_addr = pc;
   assign retire    = (state == S_WB);
   assign trap      = (state == S_TRAP);

`ifdef MULTICYCLE_CPU_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         if (state != S_TRAP) cycle_count <= cycle_count + 64'd1;
         if (retire) instret_count <= instret_count + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: ALU, load/store with wait-states, branches,
// trap, reset during fetch, and register-index trap with NREGS = 16.
module tb_multicycle_cpu;

   logic        clk = 1'b0;
   logic        rst, rst16;
   always #5 clk = ~clk;

   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, trap;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
   logic        imem_auto, imem_force;
`ifdef MULTICYCLE_CPU_PERF_EN
   logic [63:0] cyc_cnt, ins_cnt, cyc_cnt16, ins_cnt16;
`endif

   logic [31:0] prog [64];
   logic [31:0] dmem [16];

   assign imem_ack   = imem_auto ? imem_req : imem_force;
   assign imem_rdata = prog[imem_addr[7:2]];

   multicycle_cpu dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc), .retire(retire),
`ifdef MULTICYCLE_CPU_PERF_EN
      .cycle_count(cyc_cnt), .instret_count(ins_cnt),
`endif
      .trap(trap)
   );

   logic        i16_req, i16_ack, d16_req, d16_we, ret16, trap16;
   logic [31:0] i16_addr, i16_rdata, d16_addr, d16_wdata, pc16;
   logic [31:0] prog16 [4];
   assign i16_ack   = i16_req;
   assign i16_rdata = prog16[i16_addr[3:2]];

   multicycle_cpu #(.NREGS(16)) dut16 (
      .clk(clk), .rst(rst16),
      .imem_req(i16_req), .imem_addr(i16_addr), .imem_ack(i16_ack), .imem_rdata(i16_rdata),
      .dmem_req(d16_req), .dmem_we(d16_we), .dmem_addr(d16_addr), .dmem_wdata(d16_wdata),
      .dmem_ack(1'b0), .dmem_rdata(32'd0), .pc(pc16), .retire(ret16),
`ifdef MULTICYCLE_CPU_PERF_EN
      .cycle_count(cyc_cnt16), .instret_count(ins_cnt16),
`endif
      .trap(trap16)
   );

   int total = 0, bad = 0;
   int cyc = 0, nret = 0, nret16 = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (retire) nret++;
      if (ret16) nret16++;
   end

   // Data memory with programmable wait-states; records what each access presented.
   int          dwait = 3, dcnt = 0, dlen = 0, unstable = 0;
   logic [31:0] da0, dw0, last_addr, last_wdata;
   logic        dwe0, last_we;
   always @(negedge clk) begin
      if (dmem_req) begin
         if (dcnt == 0) begin
            da0 = dmem_addr; dw0 = dmem_wdata; dwe0 = dmem_we;
         end else if (dmem_addr !== da0 || dmem_wdata !== dw0 || dmem_we !== dwe0) begin
            unstable++;
         end
         if (dcnt == dwait) begin
            dmem_ack   = 1'b1;
            dmem_rdata = dmem[dmem_addr[5:2]];
            if (dmem_we) dmem[dmem_addr[5:2]] = dmem_wdata;
            last_addr = dmem_addr; last_wdata = dmem_wdata; last_we = dmem_we;
            dlen = dcnt + 1;
         end else begin
            dmem_ack = 1'b0;
         end
         dcnt++;
      end else begin
         dcnt     = 0;
         dmem_ack = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_retire(input string tag, output int stamp);
      logic seen = 1'b0;
      stamp = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (retire) begin seen = 1'b1; stamp = cyc; end
      end
      check({tag, "_retired"}, 64'(seen), 64'd1);
   endtask

   int t1, t2, t3, t4, t5, tx, saw_req, nret0;
   logic got;

   initial begin
      rst = 1'b1; rst16 = 1'b1; imem_auto = 1'b1; imem_force = 1'b0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      for (int i = 0; i < 64; i++) prog[i] = 32'h0000007F;
      for (int i = 0; i < 16; i++) dmem[i] = '0;
      prog[0]  = 32'h00500093; // addi x1,x0,5
      prog[1]  = 32'hFFD00113; // addi x2,x0,-3
      prog[2]  = 32'h002081B3; // add  x3,x1,x2
      prog[3]  = 32'h00302423; // sw   x3,8(x0)
      prog[4]  = 32'h00802203; // lw   x4,8(x0)
      prog[5]  = 32'h00008463; // beq  x1,x0,+8
      prog[6]  = 32'h00C002EF; // jal  x5,+12
      prog[9]  = 32'hFE009CE3; // bne  x1,x0,-8
      prog[7]  = 32'h0100006F; // jal  x0,+16
      prog[11] = 32'h00700013; // addi x0,x0,7
      prog[12] = 32'h00000333; // add  x6,x0,x0
      prog[13] = 32'h0000007F; // illegal
      prog16[0] = 32'h00500093; // addi x1,x0,5
      prog16[1] = 32'h00208A33; // add  x20,x1,x2
      prog16[2] = 32'h0000007F;
      prog16[3] = 32'h0000007F;

      repeat (2) @(negedge clk);
      check("rst_pc", 64'(pc), 64'd0);
      check("rst_imem_req", 64'(imem_req), 64'd0);
      check("rst_dmem_req", 64'(dmem_req), 64'd0);
      check("rst_dmem_we", 64'(dmem_we), 64'd0);
      check("rst_retire", 64'(retire), 64'd0);
      check("rst_trap", 64'(trap), 64'd0);
      check("rst_dmem_addr", 64'(dmem_addr), 64'd0);
      check("rst_dmem_wdata", 64'(dmem_wdata), 64'd0);
      rst = 1'b0;

      wait_retire("addi1", t1);
      wait_retire("addi2", t2);
      wait_retire("add", t3);
      @(negedge clk);
      check("pc_after_3", 64'(pc), 64'd12);
      check("x1", 64'(dut.regs[1]), 64'd5);
      check("x2", 64'(dut.regs[2]), 64'hFFFFFFFD);
      check("x3", 64'(dut.regs[3]), 64'd2);
      check("alu_lat_a", 64'(t2 - t1), 64'd4);
      check("alu_lat_b", 64'(t3 - t2), 64'd4);

      wait_retire("sw", t4);
      check("sw_lat", 64'(t4 - t3), 64'd8);
      check("sw_addr", 64'(last_addr), 64'd8);
      check("sw_wdata", 64'(last_wdata), 64'd2);
      check("sw_we", 64'(last_we), 64'd1);
      check("sw_req_len", 64'(dlen), 64'd4);
      wait_retire("lw", t5);
      @(negedge clk);
      check("lw_lat", 64'(t5 - t4), 64'd8);
      check("lw_we", 64'(last_we), 64'd0);
      check("x4", 64'(dut.regs[4]), 64'd2);
      check("dmem_stable", 64'(unstable), 64'd0);

      wait_retire("beq", tx); @(negedge clk);
      check("beq_not_taken_pc", 64'(pc), 64'd24);
      wait_retire("jal", tx); @(negedge clk);
      check("jal_pc", 64'(pc), 64'd36);
      check("jal_link_x5", 64'(dut.regs[5]), 64'd28);
      wait_retire("bne", tx); @(negedge clk);
      check("bne_taken_pc", 64'(pc), 64'd28);
      wait_retire("jal0", tx); @(negedge clk);
      check("jal0_pc", 64'(pc), 64'd44);
      wait_retire("addi_x0", tx); @(negedge clk);
      check("x0_zero", 64'(dut.regs[0]), 64'd0);
      wait_retire("add_x6", tx); @(negedge clk);
      check("x6", 64'(dut.regs[6]), 64'd0);
      check("pc_before_trap", 64'(pc), 64'd52);

      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (trap) got = 1'b1;
      end
      check("trap_seen", 64'(got), 64'd1);
      saw_req = 0; nret0 = nret;
      repeat (10) begin
         @(negedge clk);
         if (imem_req) saw_req++;
      end
      check("no_req_in_trap", 64'(saw_req), 64'd0);
      check("trap_sticky", 64'(trap), 64'd1);
      check("no_retire_in_trap", 64'(nret - nret0), 64'd0);
      check("retire_total", 64'(nret), 64'd11);

      // Reset while a fetch is outstanding; an ack during the post-reset idle cycle is ignored.
      imem_auto = 1'b0; imem_force = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("refetch_req", 64'(imem_req), 64'd1);
      check("regs_cleared", 64'(dut.regs[3]), 64'd0);
      check("trap_cleared", 64'(trap), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("req_dropped", 64'(imem_req), 64'd0);
      check("pc_reset", 64'(pc), 64'd0);
      nret0 = nret;
      rst = 1'b0; imem_force = 1'b1;
      @(negedge clk);
      imem_force = 1'b0;
      check("late_ack_ignored", 64'(imem_req), 64'd1);
      @(negedge clk);
      check("still_fetching", 64'(imem_req), 64'd1);
      check("no_retire_on_ack", 64'(nret - nret0), 64'd0);
      check("pc_still_reset", 64'(pc), 64'd0);
      imem_auto = 1'b1;
      wait_retire("post_rst_addi", tx); @(negedge clk);
      check("post_rst_x1", 64'(dut.regs[1]), 64'd5);

      rst16 = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (trap16) got = 1'b1;
      end
      check("n16_trap", 64'(got), 64'd1);
      check("n16_retired", 64'(nret16), 64'd1);
      check("n16_pc", 64'(pc16), 64'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
